// File: rtl/axi4_lite_bus_sunder_wr.sv
// AXI4-Lite write-path address splitter: one upstream write port routed to a low or high manager by awaddr.
// Target switches only when no write is outstanding, so B responses keep their order.
module axi4_lite_bus_sunder_wr #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int M = 0,
  parameter int D = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [A-1:0]     s_awaddr_i,
  input  logic             s_awvalid_i,
  output logic             s_awready_o,
  input  logic [8*N-1:0]   s_wdata_i,
  input  logic [N-1:0]     s_wstrb_i,
  input  logic             s_wvalid_i,
  output logic             s_wready_o,
  output logic [1:0]       s_bresp_o,
  output logic             s_bvalid_o,
  input  logic             s_bready_i,
  output logic [A-1:0]     m_awaddr_o,
  output logic [1:0]       m_awvalid_o,
  input  logic [1:0]       m_awready_i,
  output logic [8*N-1:0]   m_wdata_o,
  output logic [N-1:0]     m_wstrb_o,
  output logic [1:0]       m_wvalid_o,
  input  logic [1:0]       m_wready_i,
  input  logic [1:0][1:0]  m_bresp_i,
  input  logic [1:0]       m_bvalid_i,
  output logic [1:0]       m_bready_o
);

  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] DMAX  = CW'(D);
  localparam logic [A-1:0]  SPLIT = A'(M);

  typedef enum logic [1:0] {
    LO_ADDR = 2'b01,
    HI_ADDR = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            aw_full_q, aw_full_d;
  logic [A-1:0]    aw_addr_q, aw_addr_d;
  logic            w_full_q, w_full_d;
  logic [8*N-1:0]  w_data_q, w_data_d;
  logic [N-1:0]    w_strb_q, w_strb_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            b_full_q, b_full_d;
  logic [1:0]      b_resp_q, b_resp_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic addr_is_lo, route, issue, aw_hs, w_hs, wr_done;
  logic aw_acc, w_acc, b_cap, b_acc;

  always_comb begin
    addr_is_lo = aw_addr_q < SPLIT;
    state_d    = state_q;
    if (aw_full_q && cnt_q == '0 && !(aw_done_q || w_done_q)) begin
      if (state_q == LO_ADDR && !addr_is_lo)     state_d = HI_ADDR;
      else if (state_q == HI_ADDR && addr_is_lo) state_d = LO_ADDR;
    end
    // Route follows the next state so a switch and the first issue can share a cycle.
    route = (state_d == HI_ADDR);
    issue = aw_full_q && w_full_q && (cnt_q < DMAX) && (addr_is_lo == (state_d == LO_ADDR));

    m_awaddr_o         = aw_addr_q;
    m_wdata_o          = w_data_q;
    m_wstrb_o          = w_strb_q;
    m_awvalid_o        = '0;
    m_wvalid_o         = '0;
    m_awvalid_o[route] = issue && !aw_done_q;
    m_wvalid_o[route]  = issue && !w_done_q;
    aw_hs   = m_awvalid_o[route] && m_awready_i[route];
    w_hs    = m_wvalid_o[route] && m_wready_i[route];
    wr_done = issue && (aw_done_q || aw_hs) && (w_done_q || w_hs);

    m_bready_o        = '0;
    m_bready_o[route] = aresetn && !b_full_q;
    b_cap = m_bvalid_i[route] && m_bready_o[route];
    b_acc = b_full_q && s_bready_i;

    s_awready_o = aresetn && !aw_full_q;
    s_wready_o  = aresetn && !w_full_q;
    s_bvalid_o  = b_full_q;
    s_bresp_o   = b_resp_q;
    aw_acc = s_awvalid_i && s_awready_o;
    w_acc  = s_wvalid_i && s_wready_o;

    aw_full_d = wr_done ? 1'b0 : (aw_full_q || aw_acc);
    w_full_d  = wr_done ? 1'b0 : (w_full_q || w_acc);
    aw_addr_d = aw_acc ? s_awaddr_i : aw_addr_q;
    w_data_d  = w_acc ? s_wdata_i : w_data_q;
    w_strb_d  = w_acc ? s_wstrb_i : w_strb_q;
    aw_done_d = wr_done ? 1'b0 : (aw_done_q || aw_hs);
    w_done_d  = wr_done ? 1'b0 : (w_done_q || w_hs);
    b_full_d  = b_cap || (b_full_q && !s_bready_i);
    b_resp_d  = b_cap ? m_bresp_i[route] : b_resp_q;

    cnt_d = cnt_q;
    case ({wr_done, b_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= LO_ADDR;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_full_q  <= 1'b0;
      b_resp_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      b_full_q  <= b_full_d;
      b_resp_q  <= b_resp_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_bus_sunder_wr.sv
// Directed bench for axi4_lite_bus_sunder_wr with a write/response scoreboard and simple downstream responders.
module tb_axi4_lite_bus_sunder_wr;

  localparam logic [31:0] SPLIT = 32'h1000;

  logic             aclk;
  logic             aresetn;
  logic [31:0]      s_awaddr_i;
  logic             s_awvalid_i;
  logic             s_awready_o;
  logic [31:0]      s_wdata_i;
  logic [3:0]       s_wstrb_i;
  logic             s_wvalid_i;
  logic             s_wready_o;
  logic [1:0]       s_bresp_o;
  logic             s_bvalid_o;
  logic             s_bready_i;
  logic [31:0]      m_awaddr_o;
  logic [1:0]       m_awvalid_o;
  logic [1:0]       m_awready_i;
  logic [31:0]      m_wdata_o;
  logic [3:0]       m_wstrb_o;
  logic [1:0]       m_wvalid_o;
  logic [1:0]       m_wready_i;
  logic [1:0][1:0]  m_bresp_i;
  logic [1:0]       m_bvalid_i;
  logic [1:0]       m_bready_o;

  axi4_lite_bus_sunder_wr #(.A(32), .N(4), .M(32'h1000), .D(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        exp_aw[$];
  wr_t        exp_w[$];
  logic [1:0] exp_b[$];

  int checks = 0;
  int failures = 0;

  int         aw_n[2];
  int         w_n[2];
  int         b_sent[2];
  logic [1:0] bresp_cfg[2];
  logic       bhold[2];
  logic       model_clr;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.port = (a < SPLIT) ? 0 : 1;
    e.addr = a;
    e.data = d;
    e.strb = s;
    exp_aw.push_back(e);
    exp_w.push_back(e);
  endtask

  // Called in the drive phase; returns in the drive phase after both ingress handshakes.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ah, wh;
    push_wr(a, d, s);
    s_awaddr_i  = a;
    s_awvalid_i = 1'b1;
    s_wdata_i   = d;
    s_wstrb_i   = s;
    s_wvalid_i  = 1'b1;
    for (int i = 0; i < 100 && (s_awvalid_i || s_wvalid_i); i++) begin
      @(negedge aclk);
      ah = s_awvalid_i && s_awready_o;
      wh = s_wvalid_i && s_wready_o;
      step();
      if (ah) s_awvalid_i = 1'b0;
      if (wh) s_wvalid_i = 1'b0;
    end
    chk("write_accept", {s_awvalid_i, s_wvalid_i}, 2'b00);
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
  endtask

  function automatic int pending(input int p);
    return ((aw_n[p] < w_n[p]) ? aw_n[p] : w_n[p]) - b_sent[p];
  endfunction

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge aclk);
      idle = (exp_aw.size() == 0) && (exp_w.size() == 0) && (exp_b.size() == 0) &&
             (pending(0) == 0) && (pending(1) == 0) && !s_bvalid_o && (m_bvalid_i == 2'b00);
    end
    chk("idle_reached", idle, 1'b1);
    step();
  endtask

  // Downstream responders plus scoreboard monitors: observe at negedge, drive just after posedge.
  initial begin
    logic [1:0] awh, wh, bh;
    logic [1:0] bv[2];
    wr_t e;
    m_bvalid_i = '0;
    m_bresp_i  = '0;
    for (int p = 0; p < 2; p++) begin
      aw_n[p] = 0; w_n[p] = 0; b_sent[p] = 0;
    end
    forever begin
      @(negedge aclk);
      for (int p = 0; p < 2; p++) begin
        awh[p] = m_awvalid_o[p] && m_awready_i[p];
        wh[p]  = m_wvalid_o[p] && m_wready_i[p];
        bh[p]  = m_bvalid_i[p] && m_bready_o[p];
        bv[p]  = m_bresp_i[p];
        if (awh[p]) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
          else begin
            e = exp_aw.pop_front();
            chk("aw_port", p, e.port);
            chk("aw_addr", m_awaddr_o, e.addr);
          end
        end
        if (wh[p]) begin
          if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
          else begin
            e = exp_w.pop_front();
            chk("w_port", p, e.port);
            chk("w_data", m_wdata_o, e.data);
            chk("w_strb", m_wstrb_o, e.strb);
          end
        end
      end
      if (s_bvalid_o && s_bready_i) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
        else chk("b_resp", s_bresp_o, exp_b.pop_front());
      end
      step();
      for (int p = 0; p < 2; p++) begin
        if (model_clr) begin
          aw_n[p] = 0; w_n[p] = 0; b_sent[p] = 0;
          m_bvalid_i[p] = 1'b0;
        end else begin
          aw_n[p] += int'(awh[p]);
          w_n[p]  += int'(wh[p]);
          if (bh[p]) begin
            b_sent[p]++;
            exp_b.push_back(bv[p]);
          end
          m_bvalid_i[p] = (pending(p) > 0) && !bhold[p];
          m_bresp_i[p]  = bresp_cfg[p];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad, got;
    aresetn = 1'b0; model_clr = 1'b1;
    s_awaddr_i = '0; s_awvalid_i = 1'b0; s_wdata_i = '0; s_wstrb_i = '0; s_wvalid_i = 1'b0;
    s_bready_i = 1'b1; m_awready_i = 2'b11; m_wready_i = 2'b11;
    bresp_cfg[0] = 2'b00; bresp_cfg[1] = 2'b00; bhold[0] = 1'b0; bhold[1] = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", s_awready_o, 1'b0);
    chk("rst_wready", s_wready_o, 1'b0);
    chk("rst_m_awvalid", m_awvalid_o, 2'b00);
    chk("rst_m_wvalid", m_wvalid_o, 2'b00);
    chk("rst_m_bready", m_bready_o, 2'b00);
    chk("rst_s_bvalid", s_bvalid_o, 1'b0);
    step();
    aresetn = 1'b1; model_clr = 1'b0;
    @(negedge aclk);
    chk("post_rst_ready", {s_awready_o, s_wready_o}, 2'b11);
    chk("post_rst_bready_lo", m_bready_o, 2'b01);

    // 1: AW+W same cycle, one-cycle issue latency, B one cycle after capture
    step();
    push_wr(32'h0010, 32'hA5A5A5A5, 4'hF);
    s_awaddr_i = 32'h0010; s_awvalid_i = 1'b1; s_wdata_i = 32'hA5A5A5A5; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    @(negedge aclk);
    chk("t1_accept", {s_awready_o, s_wready_o}, 2'b11);
    step();
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    @(negedge aclk);
    chk("t1_awvalid", m_awvalid_o, 2'b01);
    chk("t1_wvalid", m_wvalid_o, 2'b01);
    chk("t1_awaddr", m_awaddr_o, 32'h0010);
    chk("t1_wdata", m_wdata_o, 32'hA5A5A5A5);
    @(negedge aclk);
    chk("t1_bvalid_early", s_bvalid_o, 1'b0);
    @(negedge aclk);
    chk("t1_bvalid", s_bvalid_o, 1'b1);
    chk("t1_bresp", s_bresp_o, 2'b00);
    wait_idle();

    // 2: target change waits for the outstanding low B
    bhold[0] = 1'b1;
    do_write(32'h0020, 32'h11111111, 4'hF);
    do_write(32'h2000, 32'h22222222, 4'hF);
    bad = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      bad |= m_awvalid_o[1] | m_wvalid_o[1];
    end
    chk("t2_hi_blocked", bad, 1'b0);
    step();
    bhold[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      got = s_bvalid_o && s_bready_i;
    end
    chk("t2_b_seen", got, 1'b1);
    chk("t2_hi_wait_b", m_awvalid_o, 2'b00);
    @(negedge aclk);
    chk("t2_hi_issue", m_awvalid_o, 2'b10);
    chk("t2_hi_addr", m_awaddr_o, 32'h2000);
    wait_idle();

    // 3: W well ahead of AW
    push_wr(32'h0040, 32'h12345678, 4'hF);
    s_wdata_i = 32'h12345678; s_wstrb_i = 4'hF; s_wvalid_i = 1'b1;
    @(negedge aclk);
    chk("t3_w_accept", s_wready_o, 1'b1);
    step();
    s_wvalid_i = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      bad |= (|m_awvalid_o) | (|m_wvalid_o) | s_wready_o;
    end
    chk("t3_held", bad, 1'b0);
    step();
    s_awaddr_i = 32'h0040; s_awvalid_i = 1'b1;
    @(negedge aclk);
    chk("t3_aw_accept", s_awready_o, 1'b1);
    step();
    s_awvalid_i = 1'b0;
    @(negedge aclk);
    chk("t3_issue", {m_awvalid_o, m_wvalid_o}, 4'b0101);
    chk("t3_wdata", m_wdata_o, 32'h12345678);
    wait_idle();

    // 4: outstanding limit D=4
    s_bready_i = 1'b0;
    for (int i = 0; i < 5; i++) do_write(32'h0100 + 32'(i * 4), 32'h40000000 + 32'(i), 4'hF);
    bad = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      bad |= |m_awvalid_o;
    end
    chk("t4_fifth_held", bad, 1'b0);
    chk("t4_b_waiting", s_bvalid_o, 1'b1);
    step();
    s_bready_i = 1'b1;
    step();
    s_bready_i = 1'b0;
    @(negedge aclk);
    chk("t4_fifth_issue", m_awvalid_o, 2'b01);
    chk("t4_fifth_addr", m_awaddr_o, 32'h0110);
    step();
    s_bready_i = 1'b1;
    wait_idle();

    // 5: W backpressure with AW already accepted; SLVERR passthrough from high side
    m_wready_i[0] = 1'b0;
    do_write(32'h0200, 32'hCAFEF00D, 4'h5);
    @(negedge aclk);
    chk("t5_issue", {m_awvalid_o, m_wvalid_o}, 4'b0101);
    bad = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      bad |= (m_awvalid_o != 2'b00) | (m_wvalid_o != 2'b01) | (m_wdata_o != 32'hCAFEF00D) | (m_wstrb_o != 4'h5);
    end
    chk("t5_w_stable", bad, 1'b0);
    step();
    m_wready_i[0] = 1'b1;
    wait_idle();
    bresp_cfg[1] = 2'b10;
    do_write(32'h3000, 32'h33333333, 4'hF);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      got = s_bvalid_o;
    end
    chk("t5_b_seen", got, 1'b1);
    chk("t5_slverr", s_bresp_o, 2'b10);
    wait_idle();

    // 6: reset with writes in flight
    bhold[1] = 1'b1;
    do_write(32'h4000, 32'h44444444, 4'hF);
    do_write(32'h4004, 32'h55555555, 4'hF);
    repeat (3) step();
    m_awready_i[1] = 1'b0; m_wready_i[1] = 1'b0;
    do_write(32'h4008, 32'h77777777, 4'hF);
    @(negedge aclk);
    chk("t6_pre_awvalid", m_awvalid_o, 2'b10);
    step();
    aresetn = 1'b0; model_clr = 1'b1;
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    @(negedge aclk);
    chk("t6_rst_readies", {s_awready_o, s_wready_o, m_bready_o}, 4'b0000);
    @(negedge aclk);
    chk("t6_rst_valids", {m_awvalid_o, m_wvalid_o, s_bvalid_o}, 5'b00000);
    step();
    aresetn = 1'b1; model_clr = 1'b0;
    bhold[1] = 1'b0; bresp_cfg[1] = 2'b00; m_awready_i = 2'b11; m_wready_i = 2'b11;
    do_write(32'h0010, 32'h66666666, 4'hF);
    @(negedge aclk);
    chk("t6_lo_route", m_awvalid_o, 2'b01);
    chk("t6_lo_addr", m_awaddr_o, 32'h0010);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
